// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the MULTU/DIVU sequencer: ALU opcodes, muldiv op
// encoding and the sequencer state enum.
package muldiv_seq_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 5'b01000;

  typedef enum logic {
    MD_MULTU = 1'b0,
    MD_DIVU  = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Bundle of request, MTHI/MTLO, ALU-borrowing and HI/LO signals between the
// EX stage (master) and the multiply/divide sequencer (slave).
interface muldiv_seq_if
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                start;
  logic                op;
  logic [WIDTH-1:0]    rs_val;
  logic [WIDTH-1:0]    rt_val;
  logic                hi_we;
  logic                lo_we;
  logic [WIDTH-1:0]    wdata;
  logic                alu_sel;
  logic [WIDTH-1:0]    alu_arg1;
  logic [WIDTH-1:0]    alu_arg2;
  logic [ALU_OP_W-1:0] alu_op;
  logic [WIDTH-1:0]    alu_result;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata, alu_result,
    input  alu_sel, alu_arg1, alu_arg2, alu_op, busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata, alu_result,
    output alu_sel, alu_arg1, alu_arg2, alu_op, busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_seq_step.sv
// One shift-add (MULTU) or restoring-divide (DIVU) iteration: picks the ALU's
// first operand and forms the next {acc, sr} pair from the ALU result.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] q_shift;
  logic             msb;
  logic             carry;

  // The ALU has no carry-out, so both carry and the divide compare are done here.
  always_comb begin
    r_shift  = {acc[WIDTH-2:0], sr[WIDTH-1]};
    q_shift  = {sr[WIDTH-2:0], 1'b0};
    msb      = acc[WIDTH-1];
    carry    = alu_result < acc;
    alu_a    = acc;
    acc_next = acc;
    sr_next  = sr;
    if (op == MD_DIVU) begin
      alu_a = r_shift;
      if (msb || (r_shift >= opnd)) begin
        acc_next = alu_result;
        sr_next  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = r_shift;
        sr_next  = q_shift;
      end
    end else if (sr[0]) begin
      acc_next = {carry, alu_result[WIDTH-1:1]};
      sr_next  = {alu_result[0], sr[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[WIDTH-1:1]};
      sr_next  = {acc[0], sr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MULTU/DIVU sequencer that borrows the EX-stage ALU for WIDTH cycles,
// stalls the pipeline while busy and owns the architectural HI/LO registers.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  md_state_e        state;
  md_state_e        state_next;
  md_op_e           op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sr_next;
  logic             div_zero;
  logic             last_iter;

  assign div_zero  = (md_op_e'(bus.op) == MD_DIVU) && (bus.rt_val == '0);
  assign last_iter = (count == LAST);

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op        (op_q),
    .acc       (acc),
    .sr        (sr),
    .opnd      (opnd),
    .alu_result(bus.alu_result),
    .alu_a     (alu_a),
    .acc_next  (acc_next),
    .sr_next   (sr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = div_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Only IDLE accepts new work or MTHI/MTLO; start takes priority over a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= MD_MULTU;
      count <= '0;
      acc   <= '0;
      sr    <= '0;
      opnd  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q  <= md_op_e'(bus.op);
            count <= '0;
            acc   <= '0;
            if (md_op_e'(bus.op) == MD_DIVU) begin
              sr   <= bus.rs_val;
              opnd <= bus.rt_val;
            end else begin
              sr   <= bus.rt_val;
              opnd <= bus.rs_val;
            end
            if (div_zero) begin
              hi_q <= bus.rs_val;
              lo_q <= DIV0_LO;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          sr    <= sr_next;
          count <= count + CNT_W'(1);
          if (last_iter) begin
            hi_q <= acc_next;
            lo_q <= sr_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.alu_sel  = 1'b0;
    bus.alu_arg1 = '0;
    bus.alu_arg2 = '0;
    bus.alu_op   = ALU_ADD;
    if (state == ST_RUN) begin
      bus.alu_sel  = 1'b1;
      bus.alu_arg1 = alu_a;
      bus.alu_arg2 = opnd;
      bus.alu_op   = (op_q == MD_DIVU) ? ALU_SUB : ALU_ADD;
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random MULTU/DIVU ops
// compared against plain 64-bit multiply and divide/modulo arithmetic.
module tb_muldiv_seq;

  localparam int          WIDTH   = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

  muldiv_seq #(
    .WIDTH  (WIDTH),
    .DIV0_LO(DIV0_LO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the EX-stage ALU (add / sub only are used here).
  assign bus.alu_result = (bus.alu_op == 5'b00001) ? (bus.alu_arg1 - bus.alu_arg2)
                                                   : (bus.alu_arg1 + bus.alu_arg2);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic op_i, input logic [31:0] a, input logic [31:0] b);
    if (!op_i) return 64'(a) * 64'(b);
    if (b == 0) return {a, DIV0_LO};
    return {a % b, a / b};
  endfunction

  // poke_kind: 0 none, 1 second start mid-run, 2 MTHI while busy, 3 MTLO with start
  task automatic run_op(input string tag, input logic op_i, input logic [31:0] a,
                        input logic [31:0] b, input int poke_kind);
    logic [63:0] exp;
    logic [31:0] hi_before;
    logic [31:0] lo_before;
    int done_at;
    int done_cnt;
    int sel_cnt;
    int busy_cnt;
    int bad_op;
    bit div0;
    exp      = model(op_i, a, b);
    div0     = op_i && (b == 0);
    done_at  = -1;
    done_cnt = 0;
    sel_cnt  = 0;
    busy_cnt = 0;
    bad_op   = 0;
    @(negedge clk);
    hi_before  = bus.hi;
    lo_before  = bus.lo;
    bus.start  = 1'b1;
    bus.op     = op_i;
    bus.rs_val = a;
    bus.rt_val = b;
    if (poke_kind == 3) begin
      bus.lo_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    for (int n = 0; n < WIDTH + 8; n++) begin
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (bus.busy) busy_cnt++;
      if (bus.alu_sel) begin
        sel_cnt++;
        if (bus.alu_op !== (op_i ? 5'b00001 : 5'b00000)) bad_op++;
      end
      if (poke_kind == 3 && n == 0) check({tag, " lo_dropped"}, 64'(bus.lo), 64'(lo_before));
      if (poke_kind == 2 && n == 4) check({tag, " hi_busy_write"}, 64'(bus.hi), 64'(hi_before));
      bus.start = (poke_kind == 1 && n == 5);
      bus.hi_we = (poke_kind == 2 && n == 3);
      if (poke_kind == 1 && n == 5) begin
        bus.rs_val = ~a;
        bus.rt_val = b + 32'd1;
      end
      if (poke_kind == 2 && n == 3) bus.wdata = 32'hBAD0_0BAD;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check({tag, " done_at"},  64'(done_at),  div0 ? 64'd0 : 64'(WIDTH));
    check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, " alu_sel"},  64'(sel_cnt),  div0 ? 64'd0 : 64'(WIDTH));
    check({tag, " busy"},     64'(busy_cnt), div0 ? 64'd1 : 64'(WIDTH + 1));
    check({tag, " alu_op"},   64'(bad_op),   64'd0);
    check({tag, " hi"},       64'(bus.hi),   64'(exp[63:32]));
    check({tag, " lo"},       64'(bus.lo),   64'(exp[31:0]));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;
    int          done_seen;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = '0;
    #1;
    check("rst busy",     64'(bus.busy),     64'd0);
    check("rst done",     64'(bus.done),     64'd0);
    check("rst alu_sel",  64'(bus.alu_sel),  64'd0);
    check("rst hi",       64'(bus.hi),       64'd0);
    check("rst lo",       64'(bus.lo),       64'd0);
    check("rst alu_arg1", 64'(bus.alu_arg1), 64'd0);
    check("rst alu_arg2", 64'(bus.alu_arg2), 64'd0);
    check("rst alu_op",   64'(bus.alu_op),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi idle", 64'(bus.hi), 64'h1234);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo idle", 64'(bus.lo), 64'h5678);

    run_op("mul 7x6",       1'b0, 32'd7,        32'd6,        0);
    run_op("mul ffxff",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op("div 100/7",     1'b1, 32'd100,      32'd7,        2);
    run_op("div 8000/3",    1'b1, 32'h8000_0000, 32'd3,        3);
    run_op("div 5/0",       1'b1, 32'd5,        32'd0,        0);

    for (int i = 0; i < 12; i++) begin
      rop = 1'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 9));
        1:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op(rop ? "rand div" : "rand mul", rop, ra, rb, 0);
    end

    run_op("mul pre-rst", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 1'b0;
    bus.rs_val = 32'h1234_5678;
    bus.rt_val = 32'h9ABC_DEF1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy",    64'(bus.busy),    64'd0);
    check("midrst alu_sel", 64'(bus.alu_sel), 64'd0);
    check("midrst hi",      64'(bus.hi),      64'd0);
    check("midrst lo",      64'(bus.lo),      64'd0);
    done_seen = 0;
    for (int n = 0; n < WIDTH + 8; n++) begin
      @(negedge clk);
      if (n == 1) rst = 1'b0;
      if (bus.done) done_seen++;
    end
    check("midrst no done", 64'(done_seen), 64'd0);
    check("midrst hi hold", 64'(bus.hi),    64'd0);

    run_op("mul post-rst", 1'b0, 32'd7, 32'd6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
